// File: rtl/vip_packet_encoder.sv
// Avalon-ST video packet encoder: turns the core's pixel stream into one VIP control packet
// plus one data packet per frame, returning sink back-pressure to the core as stall.
module vip_packet_encoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        write,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                        end_of_video,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        vip_ctrl_send,
  output logic                                        vip_ctrl_busy,
  output logic                                        stall,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  input  logic                                        dout_ready,
  output logic [2:0]                                  dbg_state
);
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CTRL_HDR  = 3'd1,
    CTRL_B1   = 3'd2,
    CTRL_B2   = 3'd3,
    CTRL_B3   = 3'd4,
    DATA_WAIT = 3'd5,
    DATA      = 3'd6
  } state_t;

  // Handshake: a beat moves when dout_valid & dout_ready; the output register
  // only reloads when o_free, so data/sop/eop stay stable while the sink stalls.
  state_t        state, state_d;
  logic          o_free, acc;
  logic          o_load, o_sop_n, o_eop_n;
  logic [DW-1:0] o_data_n;
  logic          h_load, hv, hv_n, eov_pend, eov_n, cfg_load;
  logic [DW-1:0] h_q;
  logic [15:0]   w_q, h_dim_q;
  logic [3:0]    il_q;

  // Three nibbles placed in the low bits of symbols 0..2, upper symbol bits zero.
  function automatic logic [DW-1:0] pack3(input logic [3:0] s0, input logic [3:0] s1,
                                          input logic [3:0] s2);
    logic [DW-1:0] r;
    r = '0;
    r[3:0] = s0;
    r[BITS_PER_SYMBOL +: 4] = s1;
    r[2*BITS_PER_SYMBOL +: 4] = s2;
    return r;
  endfunction

  assign o_free        = ~dout_valid | dout_ready;
  assign stall         = ~(state == DATA_WAIT || state == DATA) | ~o_free | eov_pend;
  assign acc           = write & ~stall;
  assign vip_ctrl_busy = (state != IDLE);
  assign dbg_state     = state;

  always_comb begin
    state_d  = state;
    o_load   = 1'b0;
    o_data_n = '0;
    o_sop_n  = 1'b0;
    o_eop_n  = 1'b0;
    h_load   = 1'b0;
    hv_n     = hv;
    eov_n    = eov_pend;
    cfg_load = 1'b0;
    case (state)
      IDLE: begin
        if (vip_ctrl_send) begin
          cfg_load = 1'b1;
          state_d  = CTRL_HDR;
        end
      end
      CTRL_HDR: begin
        if (o_free) begin
          o_load   = 1'b1;
          o_data_n = pack3(4'hF, 4'h0, 4'h0);
          o_sop_n  = 1'b1;
          state_d  = CTRL_B1;
        end
      end
      CTRL_B1: begin
        if (o_free) begin
          o_load   = 1'b1;
          o_data_n = pack3(w_q[15:12], w_q[11:8], w_q[7:4]);
          state_d  = CTRL_B2;
        end
      end
      CTRL_B2: begin
        if (o_free) begin
          o_load   = 1'b1;
          o_data_n = pack3(w_q[3:0], h_dim_q[15:12], h_dim_q[11:8]);
          state_d  = CTRL_B3;
        end
      end
      CTRL_B3: begin
        if (o_free) begin
          o_load   = 1'b1;
          o_data_n = pack3(h_dim_q[7:4], h_dim_q[3:0], il_q);
          o_eop_n  = 1'b1;
          state_d  = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (acc) begin
          o_load  = 1'b1;
          o_sop_n = 1'b1;
          h_load  = 1'b1;
          hv_n    = 1'b1;
          eov_n   = end_of_video;
          state_d = DATA;
        end else if (end_of_video) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (acc) begin
          o_load   = 1'b1;
          o_data_n = h_q;
          h_load   = 1'b1;
        end
        if (end_of_video) begin
          eov_n = 1'b1;
        end
        // eov_pend holds stall high, so no pixel can be accepted during the flush.
        if (eov_pend && o_free && !acc) begin
          o_load   = hv;
          o_data_n = h_q;
          o_eop_n  = hv;
          hv_n     = 1'b0;
          eov_n    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_data  <= '0;
      h_q        <= '0;
      hv         <= 1'b0;
      eov_pend   <= 1'b0;
      w_q        <= '0;
      h_dim_q    <= '0;
      il_q       <= '0;
    end else begin
      if (cfg_load) begin
        w_q     <= width_in;
        h_dim_q <= height_in;
        il_q    <= interlaced_in;
      end
      if (h_load) h_q <= data_in;
      hv       <= hv_n;
      eov_pend <= eov_n;
      if (o_free) begin
        dout_valid <= o_load;
        dout_sop   <= o_load & o_sop_n;
        dout_eop   <= o_load & o_eop_n;
        if (o_load) dout_data <= o_data_n;
      end
    end
  end
endmodule

// File: tb/tb_vip_packet_encoder.sv
// Bench for vip_packet_encoder: directed frames, then random frames against a
// beat-level model of the packets each frame must produce.
module tb_vip_packet_encoder;
  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          write, end_of_video, vip_ctrl_send, dout_ready;
  logic [W-1:0]  data_in;
  logic [15:0]   width_in, height_in;
  logic [3:0]    interlaced_in;
  logic          vip_ctrl_busy, stall, dout_valid, dout_sop, dout_eop;
  logic [W-1:0]  dout_data;
  logic [2:0]    dbg_state;

  vip_packet_encoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3)) dut (
    .clk(clk), .rst(rst), .write(write), .data_in(data_in),
    .end_of_video(end_of_video), .width_in(width_in), .height_in(height_in),
    .interlaced_in(interlaced_in), .vip_ctrl_send(vip_ctrl_send),
    .vip_ctrl_busy(vip_ctrl_busy), .stall(stall), .dout_data(dout_data),
    .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_ready(dout_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];   // {sop, eop, data}
  logic [W-1:0] pix_q[$];
  bit           rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] beat(input bit sop, input bit eop, input logic [W-1:0] d);
    return {sop, eop, d};
  endfunction

  function automatic logic [W-1:0] sym3(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c);
    return {4'h0, c, 4'h0, b, 4'h0, a};
  endfunction

  // Model: control packet carries w, h, interlace as nibbles, most significant first.
  task automatic push_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    exp_q.push_back(beat(1, 0, sym3(4'hF, 4'h0, 4'h0)));
    exp_q.push_back(beat(0, 0, sym3(w[15:12], w[11:8], w[7:4])));
    exp_q.push_back(beat(0, 0, sym3(w[3:0], h[15:12], h[11:8])));
    exp_q.push_back(beat(0, 1, sym3(h[7:4], h[3:0], il)));
  endtask

  task automatic push_data();
    if (pix_q.size() == 0) return;
    exp_q.push_back(beat(1, 0, '0));
    for (int i = 0; i < pix_q.size(); i++)
      exp_q.push_back(beat(0, i == pix_q.size() - 1, pix_q[i]));
  endtask

  // monitor / scoreboard
  logic         prev_hold = 1'b0;
  logic [W+1:0] prev_beat;
  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", dout_valid, 1);
        check("hold_beat", {dout_sop, dout_eop, dout_data}, prev_beat);
      end
      if (dout_valid && !dout_ready) check("stall_bp", stall, 1);
      if (dout_valid && dout_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat", {dout_sop, dout_eop, dout_data}, exp_q.pop_front());
      end
      prev_hold = dout_valid && !dout_ready;
      prev_beat = {dout_sop, dout_eop, dout_data};
    end
  end

  // driver tasks
  task automatic cycle_start();
    @(negedge clk);
    write = 1'b0;
    end_of_video = 1'b0;
    vip_ctrl_send = 1'b0;
    dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
  endtask

  task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                           input bit eov_last, input bit gaps, input bit model);
    int guard;
    int n;
    n = pix_q.size();
    if (model) begin
      push_ctrl(w, h, il);
      push_data();
    end
    cycle_start();
    vip_ctrl_send = 1'b1;
    width_in = w;
    height_in = h;
    interlaced_in = il;
    cycle_start();
    check("busy_after_send", vip_ctrl_busy, 1);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle_start();
      guard = 0;
      while (stall) begin
        write = $urandom_range(0, 1);
        data_in = $urandom;
        cycle_start();
        guard++;
        if (guard > 500) begin
          check("pix_timeout", guard, 0);
          return;
        end
      end
      write = 1'b1;
      data_in = pix_q[i];
      end_of_video = eov_last && (i == n - 1);
      cycle_start();
    end
    if (n == 0) begin
      guard = 0;
      while (stall) begin
        cycle_start();
        guard++;
        if (guard > 500) begin
          check("wait_timeout", guard, 0);
          return;
        end
      end
      end_of_video = 1'b1;
      cycle_start();
    end else if (!eov_last) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle_start();
      end_of_video = 1'b1;
      cycle_start();
    end
    guard = 0;
    while (vip_ctrl_busy) begin
      cycle_start();
      guard++;
      if (guard > 500) begin
        check("idle_timeout", guard, 0);
        return;
      end
    end
    check("stall_idle", stall, 1);
  endtask

  initial begin
    int guard;
    logic [15:0] rw, rh;
    rst = 1'b1;
    write = 1'b0; end_of_video = 1'b0; vip_ctrl_send = 1'b0; dout_ready = 1'b1;
    data_in = '0; width_in = '0; height_in = '0; interlaced_in = '0;
    #2;
    check("rst_valid", dout_valid, 0);
    check("rst_sop", dout_sop, 0);
    check("rst_eop", dout_eop, 0);
    check("rst_data", dout_data, 0);
    check("rst_busy", vip_ctrl_busy, 0);
    check("rst_stall", stall, 1);
    cycle_start();
    cycle_start();
    rst = 1'b0;

    // control packet with literal beats, then the four-pixel frame
    exp_q.push_back(beat(1, 0, 24'h00000F));
    exp_q.push_back(beat(0, 0, 24'h080700));
    exp_q.push_back(beat(0, 0, 24'h040000));
    exp_q.push_back(beat(0, 1, 24'h000803));
    exp_q.push_back(beat(1, 0, 24'h000000));
    exp_q.push_back(beat(0, 0, 24'h010203));
    exp_q.push_back(beat(0, 0, 24'h040506));
    exp_q.push_back(beat(0, 0, 24'h070809));
    exp_q.push_back(beat(0, 1, 24'h0A0B0C));
    pix_q = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
    run_frame(16'd1920, 16'd1080, 4'h0, 1'b0, 1'b0, 1'b0);

    // empty frame
    pix_q.delete();
    run_frame(16'd640, 16'd480, 4'h3, 1'b0, 1'b0, 1'b1);

    // last write together with end_of_video
    pix_q = '{24'hAA0001, 24'hBB0002};
    run_frame(16'd16, 16'd2, 4'h1, 1'b1, 1'b0, 1'b1);

    // reset in the middle of a control packet
    push_ctrl(16'h1234, 16'h5678, 4'h9);
    cycle_start();
    vip_ctrl_send = 1'b1;
    width_in = 16'h1234; height_in = 16'h5678; interlaced_in = 4'h9;
    cycle_start();
    cycle_start();
    cycle_start();
    check("pre_rst_valid", dout_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_busy", vip_ctrl_busy, 0);
    check("mid_rst_stall", stall, 1);
    exp_q.delete();
    cycle_start();
    rst = 1'b0;
    exp_q.push_back(beat(1, 0, 24'h00000F));
    exp_q.push_back(beat(0, 0, sym3(4'h0, 4'h0, 4'h2)));
    exp_q.push_back(beat(0, 0, sym3(4'h0, 4'h0, 4'h0)));
    exp_q.push_back(beat(0, 1, sym3(4'h2, 4'h0, 4'h0)));
    pix_q = '{24'h123456};
    push_data();
    run_frame(16'h0020, 16'h0020, 4'h0, 1'b0, 1'b0, 1'b0);

    // random frames under random back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 8);
      pix_q.delete();
      for (int i = 0; i < n; i++) pix_q.push_back($urandom);
      rw = $urandom;
      rh = $urandom;
      run_frame(rw, rh, 4'($urandom), (n >= 2) && $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
    end

    rand_ready = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      cycle_start();
      guard++;
    end
    cycle_start();
    check("drain", exp_q.size(), 0);
    check("end_valid", dout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
